// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
// Holds the state encoding, operand width, iteration count and counter width.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 6;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      BUSY = S_BUSY,
      FIX  = S_FIX,
      DONE = S_DONE
   } div_state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract dvs, keep or restore.
// Combinational, zero latency; no flow control.
module div_step
   import div_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] rem,
   input  logic [DIV_WIDTH-1:0] quo,
   input  logic [DIV_WIDTH-1:0] dvs,
   output logic [DIV_WIDTH-1:0] rem_next,
   output logic [DIV_WIDTH-1:0] quo_next
);

   logic [DIV_WIDTH-1:0] rem_sh;
   logic [DIV_WIDTH-1:0] diff;
   logic                 cout;
   logic                 unused_rem_msb;

   // rem is always below dvs <= 2^31, so its top bit is zero and can be shifted out.
   assign unused_rem_msb = rem[DIV_WIDTH-1];
   assign rem_sh         = {rem[DIV_WIDTH-2:0], quo[DIV_WIDTH-1]};

   subtract u_sub (
      .a    (rem_sh),
      .b    (dvs),
      .diff (diff),
      .cout (cout)
   );

   assign rem_next = cout ? diff : rem_sh;
   assign quo_next = {quo[DIV_WIDTH-2:0], cout};

endmodule

// File: rtl/subtract.sv
// 32-bit subtractor: diff = a - b, cout = 1 when unsigned a >= b.
// Purely combinational; no flow control.
module subtract (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] diff,
   output logic        cout
);

   assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + 33'd1;

endmodule

// File: rtl/divider.sv
// Iterative 32-bit signed divider, truncating quotient; 34 cycles start-to-ready (1 for divide-by-zero).
// No backpressure: starts outside IDLE are dropped, the ready strobe lasts one cycle.
module divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   div_state_t           state;
   logic [DIV_WIDTH-1:0] rem;
   logic [DIV_WIDTH-1:0] quo;
   logic [DIV_WIDTH-1:0] dvs;
   logic                 sign;
   logic [CNT_W-1:0]     count;

   logic [DIV_WIDTH-1:0] rem_next;
   logic [DIV_WIDTH-1:0] quo_next;
   logic [DIV_WIDTH-1:0] neg_in;
   logic [DIV_WIDTH-1:0] neg_a;
   logic [DIV_WIDTH-1:0] neg_b;
   logic                 unused_cout_a;
   logic                 unused_cout_b;

   div_step u_step (
      .rem      (rem),
      .quo      (quo),
      .dvs      (dvs),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // Shared negator: |A| while idle, -Q during the fix-up cycle.
   assign neg_in = (state == FIX) ? quo : data_operandA;

   subtract u_neg_a (
      .a    ('0),
      .b    (neg_in),
      .diff (neg_a),
      .cout (unused_cout_a)
   );

   subtract u_neg_b (
      .a    ('0),
      .b    (data_operandB),
      .diff (neg_b),
      .cout (unused_cout_b)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state          <= IDLE;
         rem            <= '0;
         quo            <= '0;
         dvs            <= '0;
         sign           <= 1'b0;
         count          <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            IDLE: begin
               if (ctrl_DIV) begin
                  if (data_operandB == '0) begin
                     data_result    <= '0;
                     data_exception <= 1'b1;
                     state          <= DONE;
                  end else begin
                     sign  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                     quo   <= data_operandA[WIDTH-1] ? neg_a : data_operandA;
                     dvs   <= data_operandB[WIDTH-1] ? neg_b : data_operandB;
                     rem   <= '0;
                     count <= '0;
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               rem   <= rem_next;
               quo   <= quo_next;
               count <= count + CNT_W'(1);
               if (count == CNT_LAST) begin
                  state <= FIX;
               end
            end
            FIX: begin
               data_result    <= sign ? neg_a : quo;
               data_exception <= 1'b0;
               state          <= DONE;
            end
            DONE: begin
               data_resultRDY <= 1'b1;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed and random checks of the signed divider: results, latency, strobe width, hold, aborts.
module tb_divider;

   logic        clock;
   logic        resetn;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic        exc;
   } vec_t;

   divider #(.WIDTH(32)) dut (
      .clock          (clock),
      .resetn         (resetn),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Launch one divide, wait for the strobe, check value/flag/latency/hold/strobe width.
   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic exp_exc);
      logic [31:0] prev;
      int          lat;
      logic        held;
      @(negedge clock);
      prev          = data_result;
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      lat  = 0;
      held = 1'b1;
      for (int k = 1; k <= 60 && lat == 0; k++) begin
         @(posedge clock);
         #1;
         if (!exp_exc && k <= 32 && data_result !== prev) held = 1'b0;
         if (data_resultRDY === 1'b1) lat = k;
      end
      check({name, " result"}, data_result, exp_q);
      check({name, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
      check({name, " latency"}, lat, exp_exc ? 32'd1 : 32'd34);
      if (!exp_exc) check({name, " hold"}, {31'd0, held}, 32'd1);
      @(posedge clock);
      #1;
      check({name, " rdy width"}, {31'd0, data_resultRDY}, 32'd0);
   endtask

   vec_t vecs[14];

   initial begin
      logic [31:0] ra, rb, rq;
      longint      sa, sb, sq;
      logic        saw_rdy;
      int          lat;

      vecs[0]  = '{32'd100,      32'd7,        32'h0000000E, 1'b0};
      vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
      vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
      vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 1'b0};
      vecs[4]  = '{32'd7,        32'd0,        32'h00000000, 1'b1};
      vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
      vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
      vecs[7]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b0};
      vecs[8]  = '{32'd0,        32'd5,        32'h00000000, 1'b0};
      vecs[9]  = '{32'd5,        32'd7,        32'h00000000, 1'b0};
      vecs[10] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
      vecs[11] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
      vecs[12] = '{32'h80000000, 32'h80000000, 32'h00000001, 1'b0};
      vecs[13] = '{32'hFFFFFFFF, 32'd2,        32'h00000000, 1'b0};

      resetn        = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      check("reset result", data_result, 32'd0);
      check("reset exception", {31'd0, data_exception}, 32'd0);
      check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
      resetn = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].exc);
      end

      // Divide-by-zero followed immediately by a start at the first IDLE edge.
      @(negedge clock);
      data_operandA = 32'd7;
      data_operandB = 32'd0;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      @(posedge clock);
      #1;
      check("b2b div0 rdy", {31'd0, data_resultRDY}, 32'd1);
      check("b2b div0 exception", {31'd0, data_exception}, 32'd1);
      data_operandA = 32'd9;
      data_operandB = 32'd3;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      lat = 0;
      for (int k = 1; k <= 60 && lat == 0; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY === 1'b1) lat = k;
      end
      check("b2b 9/3 latency", lat, 32'd34);
      check("b2b 9/3 result", data_result, 32'd3);
      check("b2b 9/3 exception", {31'd0, data_exception}, 32'd0);

      // Abort mid-divide with reset; the ignored start at E10 must not matter either.
      @(negedge clock);
      data_operandA = 32'd100;
      data_operandB = 32'd7;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      saw_rdy  = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         ctrl_DIV = (k == 10);
         if (k == 10) begin
            data_operandA = 32'd9;
            data_operandB = 32'd3;
         end
         resetn = (k != 20);
         @(posedge clock);
         #1;
         if (data_resultRDY === 1'b1) saw_rdy = 1'b1;
      end
      check("abort result", data_result, 32'd0);
      check("abort exception", {31'd0, data_exception}, 32'd0);
      check("abort rdy", {31'd0, data_resultRDY}, 32'd0);
      repeat (25) begin
         @(posedge clock);
         #1;
         if (data_resultRDY === 1'b1) saw_rdy = 1'b1;
      end
      check("abort no strobe", {31'd0, saw_rdy}, 32'd0);
      run_div("after abort 9/3", 32'd9, 32'd3, 32'd3, 1'b0);

      // Random signed pairs against a 64-bit truncating reference.
      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         if (i % 3 == 0) begin
            rb = $urandom_range(1, 100);
            if (i % 2 == 0) rb = -rb;
         end else begin
            rb = $urandom;
         end
         if (rb == 32'd0) rb = 32'd1;
         sa = $signed(ra);
         sb = $signed(rb);
         sq = sa / sb;
         rq = sq[31:0];
         run_div($sformatf("rand%0d 0x%08h/0x%08h", i, ra, rb), ra, rb, rq, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
